sort4_ctrl: RTL and testbench

SORT4_CTRL -- requirements
Module: sort4_ctrl

---
 rtl/sort4_ctrl.sv | 138 +++++++++++++
 tb/tb_sort4_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sort4_ctrl.sv
// Frame sorter: loads DEPTH bytes, bubble-sorts them in place one compare per
// cycle through a single shared comparator, then drains them in ascending order.

module cmp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       a_greater,
  output logic       a_equal,
  output logic       a_less
);
  assign a_greater = (a > b);
  assign a_equal   = (a == b);
  assign a_less    = (a < b);
endmodule

module sort4_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic [5:0] swap_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_J    = IW'(DEPTH - 2);
  localparam logic [IW-1:0] LAST_PASS = IW'(DEPTH - 2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] j;
  logic [IW-1:0] pass;
  logic          swapped;

  logic [IW-1:0] j_nxt;
  logic          a_greater;
  logic          a_equal;
  logic          a_less;
  logic          do_swap;

  assign j_nxt = j + IW'(1);

  cmp8 u_cmp (
    .a         (mem[j]),
    .b         (mem[j_nxt]),
    .a_greater (a_greater),
    .a_equal   (a_equal),
    .a_less    (a_less)
  );

  // Equal pairs are kept in place so the sort stays stable.
  assign do_swap = a_greater & ~(a_equal | a_less);

  // Outputs decode from state/index registers only; no input-to-output path.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state == SORT);
  assign out_data  = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      wr_idx     <= '0;
      rd_idx     <= '0;
      j          <= '0;
      pass       <= '0;
      swapped    <= 1'b0;
      swap_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            mem[wr_idx] <= in_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx     <= '0;
              j          <= '0;
              pass       <= '0;
              swapped    <= 1'b0;
              swap_count <= '0;
              state      <= SORT;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        SORT: begin
          if (do_swap) begin
            mem[j]     <= mem[j_nxt];
            mem[j_nxt] <= mem[j];
            swap_count <= swap_count + 6'd1;
          end
          if (j == LAST_J) begin
            j       <= '0;
            pass    <= pass + IW'(1);
            swapped <= 1'b0;
            // Early exit once a full pass made no swaps.
            if (!(swapped || do_swap) || (pass == LAST_PASS)) begin
              rd_idx <= '0;
              state  <= DRAIN;
            end
          end else begin
            j       <= j_nxt;
            swapped <= swapped | do_swap;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              wr_idx <= '0;
              state  <= LOAD;
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl: hand-computed sort results, swap counts,
// sort latency, drain back-pressure and reset in the middle of a sort.

module tb_sort4_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic [5:0] swap_count;

  int n_vec;
  int n_err;

  sort4_ctrl #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .swap_count (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Loads one frame (din[31:24] first), checks sort latency, swap count and
  // drained order. stall applies out_ready 1,0,0,1,... and holds in_valid high
  // with junk data while the block is not accepting input.
  task automatic run_frame(input logic [31:0] din, input logic [31:0] dsorted,
                           input int exp_swaps, input int exp_busy, input bit stall);
    int n;
    int k;
    int cyc;
    logic rdy;
    logic [7:0] exp_b;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = din[31 - 8*i -: 8];
      check("load_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = stall;
    in_data  = 8'hEE;
    check("sort_in_ready", 32'(in_ready), 32'd0);
    check("sort_out_valid", 32'(out_valid), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(exp_busy));
    check("swap_count", 32'(swap_count), 32'(exp_swaps));
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      rdy = stall ? ((cyc % 3) == 0) : 1'b1;
      exp_b = dsorted[31 - 8*k -: 8];
      check("drain_out_valid", 32'(out_valid), 32'd1);
      check("drain_out_data", 32'(out_data), 32'(exp_b));
      check("drain_in_ready", 32'(in_ready), 32'd0);
      out_ready = rdy;
      if (k == 3 && rdy) in_valid = 1'b0;
      @(posedge clk);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < 4) check("drain_timeout", 32'(k), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("post_swap_hold", 32'(swap_count), 32'(exp_swaps));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_swap_count", 32'(swap_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_frame(32'h40103020, 32'h10203040, 4, 9, 1'b0);
    run_frame(32'h01020304, 32'h01020304, 0, 3, 1'b0);
    run_frame(32'hFFC08000, 32'h0080C0FF, 6, 9, 1'b0);
    run_frame(32'h55550055, 32'h00555555, 2, 9, 1'b0);
    run_frame(32'h40103020, 32'h10203040, 4, 9, 1'b1);
    run_frame(32'h01020304, 32'h01020304, 0, 3, 1'b0);

    // Reset after two compares of a reverse-ordered frame.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hF0 - 8'(i * 16);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_swap_count", 32'(swap_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(32'h09070806, 32'h06070809, 5, 9, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
